// File: rtl/int_sequencer_pkg.sv
// Shared constants and types for the interrupt entry sequencer:
// state encoding, vector addresses and CCR flag positions.
package int_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int CCR_W  = 4;

    localparam logic [DATA_W-1:0] VEC_ADDR       = 8'h01;
    localparam logic [DATA_W-1:0] RESET_VEC_ADDR = 8'h00;

    // Bit positions inside the {V,C,N,Z} flag word
    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;
    localparam int CCR_V = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BND = 3'd1,
        ST_PUSH     = 3'd2,
        ST_VEC_RD   = 3'd3,
        ST_VEC_LD   = 3'd4,
        ST_ISR      = 3'd5
    } state_t;

endpackage

// File: rtl/int_sequencer_if.sv
// Signal bundle between the interrupt sequencer (master) and the
// fetch stage / stack / PC mux of the core (slave).
interface int_sequencer_if;
    import int_sequencer_pkg::*;

    // int_req is the external interrupt pin
    logic              int_req;
    logic              fetch_mid;
    logic              stall;
    logic [DATA_W-1:0] pc_cur;
    logic [CCR_W-1:0]  ccr_in;
    logic              rti_retire;
    logic              int_ack;
    logic              push_req;
    logic [DATA_W-1:0] ret_pc;
    logic [CCR_W-1:0]  ccr_saved;
    logic              flush_fetch;
    logic              vec_rd;
    logic [DATA_W-1:0] vec_addr;
    logic              pc_load_vec;
    logic              in_isr;

    modport master (
        input  int_req, fetch_mid, stall, pc_cur, ccr_in, rti_retire,
        output int_ack, push_req, ret_pc, ccr_saved, flush_fetch,
               vec_rd, vec_addr, pc_load_vec, in_isr
    );

    modport slave (
        output int_req, fetch_mid, stall, pc_cur, ccr_in, rti_retire,
        input  int_ack, push_req, ret_pc, ccr_saved, flush_fetch,
               vec_rd, vec_addr, pc_load_vec, in_isr
    );

endinterface

// File: rtl/int_sequencer_edge_latch.sv
// Rising-edge detector on the interrupt pin feeding a sticky pending flag.
// An ack clears the flag; a rise coinciding with the ack is absorbed by that entry.
module int_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic int_req,
    input  logic ack,
    output logic pending
);

    logic int_q_reg;
    logic pending_reg;
    logic rise;

    assign rise    = int_req & ~int_q_reg;
    assign pending = pending_reg;

    always_ff @(posedge clk) begin
        // Loading int_q from the pin during reset keeps a held level from firing
        int_q_reg <= int_req;
        if (!rst) begin
            pending_reg <= 1'b0;
        end else if (ack) begin
            pending_reg <= 1'b0;
        end else if (rise) begin
            pending_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: waits for an instruction boundary, saves PC/CCR,
// flushes fetch, loads the PC from the ISR vector and masks until RTI retires.
module int_sequencer
    import int_sequencer_pkg::*;
#(
    parameter logic [DATA_W-1:0] VECTOR = VEC_ADDR
) (
    input  logic            clk,
    input  logic            rst,
    int_sequencer_if.master bus
);

    state_t            state_reg;
    state_t            state_next;
    logic              pending;
    logic              boundary;
    logic              entry;
    logic              int_ack_reg;
    logic              push_req_reg;
    logic              flush_reg;
    logic              vec_rd_reg;
    logic              pc_load_reg;
    logic              in_isr_reg;
    logic [DATA_W-1:0] ret_pc_reg;
    logic [CCR_W-1:0]  ccr_saved_reg;

    int_edge_latch u_edge (
        .clk     (clk),
        .rst     (rst),
        .int_req (bus.int_req),
        .ack     (entry),
        .pending (pending)
    );

    assign boundary = ~bus.fetch_mid & ~bus.stall;
    assign entry    = (state_next == ST_PUSH) && (state_reg != ST_PUSH);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (pending) state_next = boundary ? ST_PUSH : ST_WAIT_BND;
            ST_WAIT_BND: if (boundary) state_next = ST_PUSH;
            ST_PUSH:     if (!bus.stall) state_next = ST_VEC_RD;
            ST_VEC_RD:   if (!bus.stall) state_next = ST_VEC_LD;
            ST_VEC_LD:   if (!bus.stall) state_next = ST_ISR;
            ST_ISR:      if (bus.rti_retire) state_next = pending ? ST_WAIT_BND : ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            int_ack_reg   <= 1'b0;
            push_req_reg  <= 1'b0;
            flush_reg     <= 1'b0;
            vec_rd_reg    <= 1'b0;
            pc_load_reg   <= 1'b0;
            in_isr_reg    <= 1'b0;
            ret_pc_reg    <= '0;
            ccr_saved_reg <= '0;
        end else begin
            state_reg    <= state_next;
            int_ack_reg  <= entry;
            push_req_reg <= (state_next == ST_PUSH);
            flush_reg    <= (state_next inside {ST_PUSH, ST_VEC_RD, ST_VEC_LD});
            vec_rd_reg   <= (state_next == ST_VEC_RD);
            pc_load_reg  <= (state_next == ST_VEC_LD);
            in_isr_reg   <= (state_next == ST_ISR);
            if (entry) begin
                ret_pc_reg    <= bus.pc_cur;
                ccr_saved_reg <= bus.ccr_in;
            end
        end
    end

    assign bus.int_ack     = int_ack_reg;
    assign bus.push_req    = push_req_reg;
    assign bus.flush_fetch = flush_reg;
    assign bus.vec_rd      = vec_rd_reg;
    assign bus.pc_load_vec = pc_load_reg;
    assign bus.in_isr      = in_isr_reg;
    assign bus.ret_pc      = ret_pc_reg;
    assign bus.ccr_saved   = ccr_saved_reg;
    assign bus.vec_addr    = VECTOR;

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed vector table, hand-written corner sequences
// and a random run, all cross-checked every cycle against a behavioural model.
module tb_int_sequencer;

    logic       clk = 1'b0;
    logic       t_rst = 1'b0;
    logic       t_int = 1'b0;
    logic       t_fm = 1'b0;
    logic       t_stall = 1'b0;
    logic [7:0] t_pc = 8'h00;
    logic [3:0] t_ccr = 4'h0;
    logic       t_rti = 1'b0;

    int total = 0;
    int bad = 0;
    int ack_seen = 0;
    int load_seen = 0;

    always #5 clk = ~clk;

    int_sequencer_if bus ();

    assign bus.int_req    = t_int;
    assign bus.fetch_mid  = t_fm;
    assign bus.stall      = t_stall;
    assign bus.pc_cur     = t_pc;
    assign bus.ccr_in     = t_ccr;
    assign bus.rti_retire = t_rti;

    int_sequencer dut (
        .clk (clk),
        .rst (t_rst),
        .bus (bus)
    );

    // flags order: {int_ack, push_req, flush_fetch, vec_rd, pc_load_vec, in_isr}
    logic [5:0] dut_flags;
    assign dut_flags = {bus.int_ack, bus.push_req, bus.flush_fetch,
                        bus.vec_rd, bus.pc_load_vec, bus.in_isr};

    // Behavioural model: a pending bit, a position in the 3-step entry
    // sequence (-1 = not sequencing) and a handler-active bit.
    bit         m_int_q = 1'b0;
    bit         m_pend = 1'b0;
    int         m_step = -1;
    bit         m_handler = 1'b0;
    logic [5:0] m_flags = '0;
    logic [7:0] m_ret = '0;
    logic [3:0] m_ccr = '0;

    task automatic model_step();
        bit rise;
        bit entered;
        if (!t_rst) begin
            m_int_q = t_int;
            m_pend = 1'b0;
            m_step = -1;
            m_handler = 1'b0;
            m_flags = '0;
            m_ret = '0;
            m_ccr = '0;
            return;
        end
        rise = t_int && !m_int_q;
        entered = 1'b0;
        if (m_handler) begin
            if (t_rti) m_handler = 1'b0;
        end else if (m_step >= 0) begin
            if (!t_stall) begin
                m_step++;
                if (m_step == 3) begin
                    m_step = -1;
                    m_handler = 1'b1;
                end
            end
        end else if (m_pend && !t_fm && !t_stall) begin
            entered = 1'b1;
            m_step = 0;
        end
        m_pend = entered ? 1'b0 : (m_pend || rise);
        m_int_q = t_int;
        if (entered) begin
            m_ret = t_pc;
            m_ccr = t_ccr;
        end
        m_flags = {entered, m_step == 0, m_step >= 0, m_step == 1, m_step == 2, m_handler};
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h @%0t", name, got, want, $time);
        end
    endtask

    // One clock: advance model with the inputs present at the edge, then compare
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (bus.int_ack === 1'b1) ack_seen++;
        if (bus.pc_load_vec === 1'b1) load_seen++;
        check("model", {6'd0, dut_flags, bus.ret_pc, bus.ccr_saved, bus.vec_addr},
                       {6'd0, m_flags, m_ret, m_ccr, 8'h01});
    endtask

    task automatic drive(input logic i, input logic fm, input logic st,
                         input logic [7:0] pc, input logic [3:0] ccr, input logic rti);
        t_int = i; t_fm = fm; t_stall = st; t_pc = pc; t_ccr = ccr; t_rti = rti;
    endtask

    typedef struct {
        logic       i_int;
        logic       fm;
        logic       st;
        logic       rti;
        logic [7:0] pc;
        logic [3:0] ccr;
        logic [5:0] flags;
        logic [7:0] ret;
        logic [3:0] csv;
    } vec_t;

    vec_t vecs [23];

    initial begin
        // in_isr seen-in-window flag for bounded waits
        bit got;

        vecs = '{
            // int rises in IDLE, boundary ready
            '{1, 0, 0, 0, 8'h04, 4'h4, 6'b000000, 8'h00, 4'h0},
            '{1, 0, 0, 0, 8'h04, 4'h4, 6'b111000, 8'h04, 4'h4},
            '{1, 0, 0, 0, 8'h04, 4'h4, 6'b001100, 8'h04, 4'h4},
            '{1, 0, 0, 0, 8'h04, 4'h4, 6'b001010, 8'h04, 4'h4},
            '{1, 0, 0, 0, 8'h04, 4'h4, 6'b000001, 8'h04, 4'h4},
            '{1, 0, 0, 0, 8'h04, 4'h4, 6'b000001, 8'h04, 4'h4},
            '{1, 0, 0, 1, 8'h04, 4'h4, 6'b000000, 8'h04, 4'h4},
            '{0, 0, 0, 0, 8'h33, 4'hF, 6'b000000, 8'h04, 4'h4},
            // stall for two cycles in VEC_RD
            '{1, 0, 0, 0, 8'h10, 4'h3, 6'b000000, 8'h04, 4'h4},
            '{1, 0, 0, 0, 8'h10, 4'h3, 6'b111000, 8'h10, 4'h3},
            '{1, 0, 0, 0, 8'h10, 4'h3, 6'b001100, 8'h10, 4'h3},
            '{1, 0, 1, 0, 8'h10, 4'h3, 6'b001100, 8'h10, 4'h3},
            '{1, 0, 1, 0, 8'h10, 4'h3, 6'b001100, 8'h10, 4'h3},
            '{1, 0, 0, 0, 8'h10, 4'h3, 6'b001010, 8'h10, 4'h3},
            '{1, 0, 0, 0, 8'h10, 4'h3, 6'b000001, 8'h10, 4'h3},
            '{0, 0, 0, 1, 8'h10, 4'h3, 6'b000000, 8'h10, 4'h3},
            // fetch_mid delays PUSH; ret_pc is the PC after the second byte
            '{1, 1, 0, 0, 8'h20, 4'h5, 6'b000000, 8'h10, 4'h3},
            '{1, 1, 0, 0, 8'h20, 4'h5, 6'b000000, 8'h10, 4'h3},
            '{1, 0, 0, 0, 8'h22, 4'h5, 6'b111000, 8'h22, 4'h5},
            '{1, 0, 0, 0, 8'h22, 4'h5, 6'b001100, 8'h22, 4'h5},
            '{1, 0, 0, 0, 8'h22, 4'h5, 6'b001010, 8'h22, 4'h5},
            '{1, 0, 0, 0, 8'h22, 4'h5, 6'b000001, 8'h22, 4'h5},
            '{0, 0, 0, 1, 8'h22, 4'h5, 6'b000000, 8'h22, 4'h5}
        };

        // Reset with int held high: no entry afterwards
        drive(1, 0, 0, 8'h00, 4'h0, 0);
        t_rst = 1'b0;
        repeat (3) cyc();
        check("reset_flags", {26'd0, dut_flags}, 32'd0);
        check("reset_vec_addr", {24'd0, bus.vec_addr}, 32'h01);
        t_rst = 1'b1;
        ack_seen = 0;
        repeat (10) cyc();
        check("held_level_no_ack", ack_seen, 0);
        $display("seq reset_held_int acks=%0d", ack_seen);
        t_int = 1'b0;
        repeat (2) cyc();

        foreach (vecs[i]) begin
            drive(vecs[i].i_int, vecs[i].fm, vecs[i].st, vecs[i].pc, vecs[i].ccr, vecs[i].rti);
            cyc();
            check($sformatf("vec%0d", i), {12'd0, dut_flags, bus.ret_pc, bus.ccr_saved},
                  {12'd0, vecs[i].flags, vecs[i].ret, vecs[i].csv});
            $display("vec %0d int=%b fm=%b st=%b rti=%b flags=%b ret=%h ccr=%h",
                     i, vecs[i].i_int, vecs[i].fm, vecs[i].st, vecs[i].rti,
                     dut_flags, bus.ret_pc, bus.ccr_saved);
        end
        drive(0, 0, 0, 8'h40, 4'h1, 0);
        cyc();

        // Back-to-back: two extra rises during ISR yield exactly one more entry
        ack_seen = 0;
        t_int = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            got = bus.in_isr;
        end
        check("b2b_reach_isr", {31'd0, got}, 1);
        t_int = 0; cyc();
        t_int = 1; cyc();
        t_int = 0; cyc();
        t_int = 1; cyc();
        t_int = 0; cyc();
        t_rti = 1; cyc();
        check("b2b_wait_bnd", {26'd0, dut_flags}, 32'd0);
        t_rti = 0; cyc();
        check("b2b_push", {26'd0, dut_flags}, {26'd0, 6'b111000});
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            got = bus.in_isr;
        end
        check("b2b_reach_isr2", {31'd0, got}, 1);
        t_rti = 1; cyc();
        t_rti = 0;
        repeat (10) cyc();
        check("b2b_ack_count", ack_seen, 2);
        $display("seq back_to_back acks=%0d", ack_seen);

        // Reset during VEC_RD with a second request pending: aborts, no entry
        t_int = 1; cyc();
        cyc();
        check("rst_mid_push", {26'd0, dut_flags}, {26'd0, 6'b111000});
        t_int = 0; cyc();
        check("rst_mid_vecrd", {26'd0, dut_flags}, {26'd0, 6'b001100});
        t_int = 1; t_stall = 1; cyc();
        ack_seen = 0;
        load_seen = 0;
        t_rst = 0; t_stall = 0; cyc();
        check("rst_mid_flags", {26'd0, dut_flags}, 32'd0);
        t_rst = 1;
        repeat (10) cyc();
        check("rst_mid_no_load", load_seen, 0);
        check("rst_mid_no_ack", ack_seen, 0);
        $display("seq reset_mid_sequence acks=%0d loads=%0d", ack_seen, load_seen);
        t_int = 0;
        repeat (2) cyc();

        // Random traffic against the model
        for (int k = 0; k < 2000; k++) begin
            t_rst   = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 5) == 0) t_int = ~t_int;
            t_fm    = ($urandom_range(0, 3) == 0);
            t_stall = ($urandom_range(0, 4) == 0);
            t_rti   = ($urandom_range(0, 9) == 0);
            t_pc    = 8'($urandom);
            t_ccr   = 4'($urandom);
            cyc();
        end
        $display("seq random cycles=2000 acks=%0d", ack_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Interrupt front-end of the 8-bit pipelined core. It sits between the external int pin and the fetch stage, and drives the fetch-stage PC mux.
- Detects an interrupt request and waits for an instruction boundary.
- Runs a fixed entry sequence: save return PC and CCR, flush fetch, load PC from M[VEC_ADDR]. Then masks further entries until RTI retires.

Parameters:
- VEC_ADDR, 8'h01, memory address of the ISR vector (M[0] is the reset vector).
- DATA_W, 8, PC/data width.
- CCR_W, 4, flag width {V,C,N,Z}.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- int  in  1  external interrupt request, level, asynchronous to the program.
- fetch_mid  in  1  fetch holds the first byte of a two-byte instruction (LDM/LDD/STD/JMP imm).
- stall  in  1  hazard stall; the PC is frozen this cycle.
- pc_cur  in  DATA_W  PC of the next instruction to be fetched.
- ccr_in  in  CCR_W  current CCR.
- rti_retire  in  1  one-cycle pulse when RTI completes writeback.
- int_ack  out  1  one-cycle pulse on sequence entry.
- push_req  out  1  request: stack-write ret_pc at SP, then SP--.
- ret_pc  out  DATA_W  captured return address.
- ccr_saved  out  CCR_W  captured flags, held for RTI restore.
- flush_fetch  out  1  kill the instruction in fetch/decode.
- vec_rd  out  1  memory read of VEC_ADDR this cycle.
- vec_addr  out  DATA_W  constant VEC_ADDR.
- pc_load_vec  out  1  PC <= memory read data this cycle.
- in_isr  out  1  handler active; interrupts masked.

Behaviour:
- Reset:
  - rst low at a rising clk returns to IDLE.
  - Clears the pending latch and the edge-detect register. The edge register loads 1 if int is high, so a level already held through reset does not fire.
  - All outputs are 0 except vec_addr = VEC_ADDR.
  - Reset mid-sequence aborts the sequence with no push.
- Request detect:
  - int_q registers int.
  - rise = int & ~int_q sets the pending flag.
  - A steady high level triggers only once.
  - pending clears in the cycle int_ack fires.
  - A rise while pending or in_isr is held as one pending level; extra rises are lost.
- States: IDLE, WAIT_BND, PUSH, VEC_RD, VEC_LD, ISR.
- IDLE:
  - pending=1 moves to WAIT_BND.
  - If fetch_mid=0 and stall=0 in the same cycle, go directly to PUSH.
- WAIT_BND:
  - Stay while fetch_mid or stall is high.
  - Otherwise go to PUSH.
- PUSH (1 cycle):
  - int_ack=1, push_req=1, flush_fetch=1.
  - ret_pc <= pc_cur and ccr_saved <= ccr_in, registered on entry to PUSH.
  - Moves to VEC_RD.
- VEC_RD (1 cycle): vec_rd=1, flush_fetch=1; then VEC_LD.
- VEC_LD (1 cycle):
  - pc_load_vec=1, flush_fetch=1.
  - in_isr rises the next cycle; then ISR.
- ISR:
  - in_isr=1.
  - Leaves on rti_retire. If pending=1, go to WAIT_BND (back-to-back service); else go to IDLE.
- Entry latency: from rise sampled, worst case 4 cycles to the PC holding the vector (boundary ready). The first ISR instruction is fetched at cycle 5.
- stall during PUSH/VEC_RD/VEC_LD:
  - The sequence holds its state and outputs until stall drops.
  - int_ack is still a single pulse (first PUSH cycle only).
- rti_retire outside ISR is ignored.
- ret_pc and ccr_saved are held until the next PUSH.
- Arithmetic: none beyond the PC capture. Widths are exact, no truncation.

Decomposition:
- Shared package / header holds:
  - state encoding constants (3-bit): IDLE=0, WAIT_BND=1, PUSH=2, VEC_RD=3, VEC_LD=4, ISR=5;
  - VEC_ADDR and RESET_VEC_ADDR (8'h00);
  - CCR bit indices Z=0, N=1, C=2, V=3.
- One sub-module, int_edge_latch: the int_q register, rise detect, and a pending flag with set/clear priority (set wins when the same cycle has no ack).
- The FSM and capture registers stay in int_sequencer.

Test Plan:
- Reset with int held high, then release → no int_ack within 10 cycles, state IDLE, all outputs 0.
- int rises in IDLE, pc_cur=8'h04, fetch_mid=0, ccr_in=4'b0100:
  - next cycle int_ack=push_req=1, ret_pc=8'h04, ccr_saved=4'b0100;
  - vec_rd follows 1 cycle later, then pc_load_vec;
  - in_isr=1 from the cycle after pc_load_vec.
- int rises while fetch_mid=1 for 2 cycles → PUSH is delayed until fetch_mid=0. ret_pc equals pc_cur at that cycle (after the second byte).
- stall=1 for 2 cycles during VEC_RD → vec_rd held 3 cycles, pc_load_vec single cycle after, int_ack pulsed once total.
- Second int rise during ISR, then rti_retire:
  - goes to WAIT_BND, then PUSH the next cycle;
  - a third rise during ISR produces only one extra entry.
- rst low during VEC_RD → next cycle IDLE, pc_load_vec never asserts, pending=0.
